mem_resp_model: RTL and testbench
=================================

Name: mem_resp_model

Overview:
- Downstream responder for the PicoRV32 native memory interface (mem_valid/mem_ready handshake).
- Provides a word-organised RAM with a programmable wait-state count.
- Checks the requester's protocol and flags misaligned or out-of-range accesses.
- Used as the memory side of CPU benches and formal/cover harnesses in place of unconstrained mem_ready/mem_rdata inputs.

Parameters:
- DEPTH, 1024, RAM size in 32-bit words; power of two, at least 4.
- MAX_WAIT, 15, largest honoured wait_cfg value; wait_cfg is clamped to this.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- resetn  input  1  asynchronous active-low reset.
- mem_valid  input  1  request valid from CPU.
- mem_instr  input  1  request is an instruction fetch.
- mem_addr  input  32  byte address.
- mem_wdata  input  32  write data.
- mem_wstrb  input  4  byte write enables; 0 means read.
- mem_ready  output  1  response strobe, registered.
- mem_rdata  output  32  read data, valid while mem_ready=1.
- wait_cfg  input  4  wait states per request, sampled at request capture.
- ld_en  input  1  backdoor word write enable.
- ld_addr  input  32  backdoor word index.
- ld_data  input  32  backdoor write data.
- proto_err  output  1  sticky protocol violation.
- range_err  output  1  sticky misaligned or out-of-range access.

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE, mem_ready=0, mem_rdata=0, proto_err=0, range_err=0, wait counter=0, statistics counters=0.
  - RAM contents are not reset.
- FSM states:
  - IDLE: if mem_valid=1, latch addr/wdata/wstrb/instr and load cnt=min(wait_cfg,MAX_WAIT); go to WAIT if cnt>0, else RESP.
  - WAIT: decrement cnt each cycle; go to RESP when cnt reaches 0.
  - RESP: mem_ready=1 for exactly this one cycle, then go to IDLE.
- Latency:
  - Request first seen in IDLE at cycle t produces mem_ready=1 in cycle t+1+wait_cfg.
  - wait_cfg=0 gives a one-cycle response.
  - A new request may be captured in the cycle after RESP (back-to-back issue every 2+wait_cfg cycles).
- Read (wstrb==0): mem_rdata=RAM[addr[ADDR_W+1:2]] during RESP; mem_rdata=0 in all other cycles.
- Write (wstrb!=0):
  - Byte lanes with wstrb[i]=1 are written at the edge that ends RESP.
  - mem_rdata=0 during a write response.
- Range checks:
  - addr[1:0]!=0 or addr>=DEPTH*4: the response is still given (same latency), reads return 0, writes are dropped, and range_err is set.
- Protocol checks (sticky proto_err):
  - In WAIT or RESP: mem_valid=0, or any of addr/wdata/wstrb/instr differs from the latched value.
  - In IDLE: mem_wstrb!=0 with mem_instr=1 at capture.
- Backdoor load:
  - ld_en is honoured in any state; RAM[ld_addr[ADDR_W-1:0]] <= ld_data.
  - If ld_en and a RESP write hit the same word on the same edge, the CPU write wins on its strobed bytes.
  - If ld_en and a RESP read target the same word, mem_rdata returns the old data.
- Reset mid-transaction: the request is abandoned, no write occurs, and mem_ready stays 0.

Optional Feature:
- MEM_RESP_STATS_EN: adds outputs cnt_fetch, cnt_dread, cnt_dwrite (32-bit each).
  - Each increments at the edge ending RESP, for an instr, data-read, or data-write response respectively.
  - All are cleared on reset and wrap modulo 2^32.
- Without the macro: these ports and counters do not exist.

Decomposition:
- Package mem_resp_pkg holds:
  - FSM state encoding (IDLE/WAIT/RESP);
  - ADDR_W = log2(DEPTH) derivation function;
  - wstrb read/write classification constant.
- Sub-module mem_resp_ram holds:
  - DEPTH x 32 RAM with 4 byte-lane write enables, one synchronous-write port and one backdoor port;
  - asynchronous read at the latched index.

Test Plan:
- Backdoor load RAM[4]=0xDEADBEEF; read addr 0x10, wait_cfg=0 -> mem_ready one cycle after capture, mem_rdata=0xDEADBEEF, no error flags.
- Write addr 0x10, wdata 0x11223344, wstrb 4'b0101, then read 0x10 -> mem_rdata=0xDE22BE44.
- wait_cfg=3 read -> mem_ready exactly 4 cycles after capture; wait_cfg changed mid-WAIT has no effect.
- Drop mem_valid during WAIT -> proto_err=1 and stays 1 until reset; response still completes.
- Read addr 0x2 and addr DEPTH*4 -> mem_rdata=0, range_err=1, RAM unchanged.
- With MEM_RESP_STATS_EN: 3 fetches, 2 loads, 1 store -> cnt_fetch=3, cnt_dread=2, cnt_dwrite=1; assert resetn=0 mid-WAIT -> all counters 0 and mem_ready=0.

Source files
------------

// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg: shared FSM encoding, index-width helper and strobe classification for mem_resp_model.
package mem_resp_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam logic [3:0] WSTRB_READ = 4'b0000;
  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction
endpackage

// File: rtl/mem_resp_ram.sv
// mem_resp_ram: DEPTH x 32 RAM with byte-lane CPU write port, backdoor word port and async read.
module mem_resp_ram #(
  parameter int DEPTH = 1024,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic [3:0]    we,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_idx,
  input  logic [31:0]   ld_data,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH];
  // The CPU lane writes come last so they override a same-word backdoor load.
  always_ff @(posedge clk) begin
    if (ld_en) mem[ld_idx] <= ld_data;
    for (int i = 0; i < 4; i++)
      if (we[i]) mem[idx][i*8 +: 8] <= wdata[i*8 +: 8];
  end
  assign rdata = mem[idx];
endmodule

// File: rtl/mem_resp_model.sv
// mem_resp_model: PicoRV32 native-interface memory responder with wait states and protocol/range checking.
// Define MEM_RESP_STATS_EN to add the cnt_fetch/cnt_dread/cnt_dwrite response counters.
module mem_resp_model
  import mem_resp_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  input  logic [3:0]  wait_cfg,
  input  logic        ld_en,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data,
  output logic        proto_err,
`ifdef MEM_RESP_STATS_EN
  output logic        range_err,
  output logic [31:0] cnt_fetch,
  output logic [31:0] cnt_dread,
  output logic [31:0] cnt_dwrite
`else
  output logic        range_err
`endif
);
  localparam int AW = addr_w(DEPTH);
  localparam logic [3:0] MW = 4'(MAX_WAIT);
  state_t      state;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  wstrb_q, cnt, wait_eff;
  logic        instr_q, bad, mismatch, unused_ok;
  logic [31:0] ram_rdata;
  assign wait_eff = (wait_cfg > MW) ? MW : wait_cfg;
  assign bad = (|addr_q[1:0]) || (addr_q[31:AW+2] != '0);
  assign mismatch = !mem_valid || mem_addr != addr_q || mem_wdata != wdata_q ||
                    mem_wstrb != wstrb_q || mem_instr != instr_q;
  assign mem_rdata = (mem_ready && wstrb_q == WSTRB_READ && !bad) ? ram_rdata : '0;
  assign unused_ok = ^ld_addr[31:AW];
  mem_resp_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk    (clk),
    .we     ((state == RESP && !bad) ? wstrb_q : 4'b0000),
    .idx    (addr_q[AW+1:2]),
    .wdata  (wdata_q),
    .ld_en  (ld_en),
    .ld_idx (ld_addr[AW-1:0]),
    .ld_data(ld_data),
    .rdata  (ram_rdata)
  );
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      mem_ready <= 1'b0;
      proto_err <= 1'b0;
      range_err <= 1'b0;
      cnt       <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      instr_q   <= 1'b0;
`ifdef MEM_RESP_STATS_EN
      cnt_fetch  <= '0;
      cnt_dread  <= '0;
      cnt_dwrite <= '0;
`endif
    end else begin
      mem_ready <= 1'b0;
      case (state)
        IDLE: if (mem_valid) begin
          addr_q  <= mem_addr;
          wdata_q <= mem_wdata;
          wstrb_q <= mem_wstrb;
          instr_q <= mem_instr;
          cnt     <= wait_eff;
          if (mem_instr && mem_wstrb != WSTRB_READ) proto_err <= 1'b1;
          if (wait_eff == 4'd0) begin
            state     <= RESP;
            mem_ready <= 1'b1;
          end else state <= WAIT;
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (mismatch) proto_err <= 1'b1;
          if (cnt == 4'd1) begin
            state     <= RESP;
            mem_ready <= 1'b1;
          end
        end
        RESP: begin
          state <= IDLE;
          if (mismatch) proto_err <= 1'b1;
          if (bad) range_err <= 1'b1;
`ifdef MEM_RESP_STATS_EN
          if (instr_q) cnt_fetch <= cnt_fetch + 32'd1;
          else if (wstrb_q == WSTRB_READ) cnt_dread <= cnt_dread + 32'd1;
          else cnt_dwrite <= cnt_dwrite + 32'd1;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_resp_model.sv
// tb_mem_resp_model: directed self-checking bench for mem_resp_model (stats checks when MEM_RESP_STATS_EN is defined).
module tb_mem_resp_model;
  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        mem_valid = 1'b0, mem_instr = 1'b0;
  logic [31:0] mem_addr = '0, mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0, wait_cfg = '0;
  logic        ld_en = 1'b0;
  logic [31:0] ld_addr = '0, ld_data = '0;
  logic        mem_ready, proto_err, range_err;
  logic [31:0] mem_rdata;
`ifdef MEM_RESP_STATS_EN
  logic [31:0] cnt_fetch, cnt_dread, cnt_dwrite;
`endif
  int errors = 0, checks = 0;
  int lat;
  logic [31:0] rd;
  logic rdy_after;

  mem_resp_model dut (
    .clk(clk), .resetn(resetn), .mem_valid(mem_valid), .mem_instr(mem_instr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .wait_cfg(wait_cfg),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
`ifdef MEM_RESP_STATS_EN
    .cnt_fetch(cnt_fetch), .cnt_dread(cnt_dread), .cnt_dwrite(cnt_dwrite),
`endif
    .proto_err(proto_err), .range_err(range_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] idx, input logic [31:0] d);
    ld_en = 1'b1;
    ld_addr = idx;
    ld_data = d;
    tick();
    ld_en = 1'b0;
  endtask

  // Issues one request and holds it through the edge that ends RESP.
  task automatic req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                     input logic ins, input logic [3:0] w, input bit chg, input bit drop,
                     output int l, output logic [31:0] r, output logic ra);
    mem_addr = a;
    mem_wdata = d;
    mem_wstrb = s;
    mem_instr = ins;
    wait_cfg = w;
    mem_valid = 1'b1;
    l = 0;
    do begin
      tick();
      l++;
      if (chg && l == 1) wait_cfg = 4'd0;
      if (drop) mem_valid = (l != 1);
    end while (!mem_ready && l < 40);
    r = mem_rdata;
    tick();
    ra = mem_ready;
    mem_valid = 1'b0;
    mem_wstrb = '0;
    mem_instr = 1'b0;
  endtask

  initial begin
    #2 resetn = 1'b0;
    tick();
    tick();
    check("rst_ready", {31'b0, mem_ready}, 32'd0);
    check("rst_rdata", mem_rdata, 32'd0);
    check("rst_proto", {31'b0, proto_err}, 32'd0);
    check("rst_range", {31'b0, range_err}, 32'd0);
    resetn = 1'b1;
    tick();

    load(32'd4, 32'hDEADBEEF);
    req(32'h10, 32'h0, 4'h0, 1'b0, 4'd0, 1'b0, 1'b0, lat, rd, rdy_after);
    check("rd0_lat", lat, 32'd1);
    check("rd0_data", rd, 32'hDEADBEEF);
    check("rd0_once", {31'b0, rdy_after}, 32'd0);
    check("rd0_proto", {31'b0, proto_err}, 32'd0);
    check("rd0_range", {31'b0, range_err}, 32'd0);

    req(32'h10, 32'h11223344, 4'b0101, 1'b0, 4'd0, 1'b0, 1'b0, lat, rd, rdy_after);
    check("wr_lat", lat, 32'd1);
    check("wr_rdata0", rd, 32'd0);
    req(32'h10, 32'h0, 4'h0, 1'b0, 4'd0, 1'b0, 1'b0, lat, rd, rdy_after);
    check("wr_readback", rd, 32'hDE22BE44);

    req(32'h10, 32'h0, 4'h0, 1'b0, 4'd3, 1'b1, 1'b0, lat, rd, rdy_after);
    check("w3_lat", lat, 32'd4);
    check("w3_data", rd, 32'hDE22BE44);
    check("w3_once", {31'b0, rdy_after}, 32'd0);
    req(32'h10, 32'h0, 4'h0, 1'b0, 4'd7, 1'b0, 1'b0, lat, rd, rdy_after);
    check("w7_lat", lat, 32'd8);

    load(32'd0, 32'hCAFEF00D);
    req(32'h2, 32'h0, 4'h0, 1'b0, 4'd0, 1'b0, 1'b0, lat, rd, rdy_after);
    check("mis_lat", lat, 32'd1);
    check("mis_rdata", rd, 32'd0);
    check("mis_range", {31'b0, range_err}, 32'd1);
    req(32'h1000, 32'h55555555, 4'hF, 1'b0, 4'd1, 1'b0, 1'b0, lat, rd, rdy_after);
    check("oor_wr_lat", lat, 32'd2);
    req(32'h1000, 32'h0, 4'h0, 1'b0, 4'd0, 1'b0, 1'b0, lat, rd, rdy_after);
    check("oor_rdata", rd, 32'd0);
    req(32'h12, 32'h0, 4'hF, 1'b0, 4'd0, 1'b0, 1'b0, lat, rd, rdy_after);
    req(32'h0, 32'h0, 4'h0, 1'b0, 4'd0, 1'b0, 1'b0, lat, rd, rdy_after);
    check("oor_word0", rd, 32'hCAFEF00D);
    req(32'h10, 32'h0, 4'h0, 1'b0, 4'd0, 1'b0, 1'b0, lat, rd, rdy_after);
    check("mis_word4", rd, 32'hDE22BE44);
    check("range_proto", {31'b0, proto_err}, 32'd0);

    req(32'h10, 32'h0, 4'h0, 1'b0, 4'd3, 1'b0, 1'b1, lat, rd, rdy_after);
    check("drop_lat", lat, 32'd4);
    check("drop_proto", {31'b0, proto_err}, 32'd1);
    req(32'h10, 32'h0, 4'h0, 1'b0, 4'd0, 1'b0, 1'b0, lat, rd, rdy_after);
    check("drop_sticky", {31'b0, proto_err}, 32'd1);

    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
    check("rst2_proto", {31'b0, proto_err}, 32'd0);
    check("rst2_range", {31'b0, range_err}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      req(32'h10, 32'h0, 4'h0, 1'b1, 4'd0, 1'b0, 1'b0, lat, rd, rdy_after);
      check("fetch_data", rd, 32'hDE22BE44);
    end
    for (int i = 0; i < 2; i++) begin
      req(32'h0, 32'h0, 4'h0, 1'b0, 4'd1, 1'b0, 1'b0, lat, rd, rdy_after);
      check("load_data", rd, 32'hCAFEF00D);
    end
    req(32'h20, 32'h12345678, 4'hF, 1'b0, 4'd0, 1'b0, 1'b0, lat, rd, rdy_after);
    req(32'h20, 32'h0, 4'h0, 1'b0, 4'd0, 1'b0, 1'b0, lat, rd, rdy_after);
    check("store_back", rd, 32'h12345678);
`ifdef MEM_RESP_STATS_EN
    check("cnt_fetch", cnt_fetch, 32'd3);
    check("cnt_dread", cnt_dread, 32'd3);
    check("cnt_dwrite", cnt_dwrite, 32'd1);
`endif

    mem_addr = 32'h10;
    mem_wdata = 32'h0;
    mem_wstrb = 4'hF;
    mem_instr = 1'b0;
    wait_cfg = 4'd5;
    mem_valid = 1'b1;
    tick();
    tick();
    resetn = 1'b0;
    mem_valid = 1'b0;
    mem_wstrb = '0;
    #1;
    check("midrst_ready", {31'b0, mem_ready}, 32'd0);
`ifdef MEM_RESP_STATS_EN
    check("midrst_fetch", cnt_fetch, 32'd0);
    check("midrst_dread", cnt_dread, 32'd0);
    check("midrst_dwrite", cnt_dwrite, 32'd0);
`endif
    tick();
    resetn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("midrst_idle", {31'b0, mem_ready}, 32'd0);
    end
    req(32'h10, 32'h0, 4'h0, 1'b0, 4'd0, 1'b0, 1'b0, lat, rd, rdy_after);
    check("midrst_nowr", rd, 32'hDE22BE44);
    check("midrst_proto", {31'b0, proto_err}, 32'd0);

    req(32'h40, 32'hA5A5A5A5, 4'h1, 1'b1, 4'd0, 1'b0, 1'b0, lat, rd, rdy_after);
    check("ifetch_wr_proto", {31'b0, proto_err}, 32'd1);
    check("ifetch_wr_range", {31'b0, range_err}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
